autotest_result_buffer: RTL and testbench

- Downstream of the SD autotest sequencer.
- Captures header fields and per-iteration 32-bit timer results in a local word buffer.
- Serves the result record as a 512-byte stream to the SD host's byte-write path.
- Lets the sequencer build the full result block before writing, instead of computing each byte on the fly inside its write loop.

---
 rtl/autotest_result_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_autotest_result_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/autotest_result_buffer.sv
// autotest_result_buffer
//   Collects the SD autotest header and per-iteration 32-bit timer results
//   in a local word buffer. It then serves the finished record as a
//   BLOCK_BYTES byte stream to the SD host byte-write path, one byte per
//   request.
//
//   Optional feature macro: AUTOTEST_RESULT_CHECKSUM_EN
//     When it is defined, the last record byte is the running XOR of all
//     earlier bytes, and the result capacity shrinks by one word.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   clear                         start a new record, latch header inputs
//   hdr_signature/iteration/
//   hdr_n_blocks/sclk_speed/cmd18 header field inputs (latched on clear)
//   res_valid, res_data           offered timer result word
//   res_ready                     result accepted this cycle
//   full, overflow                buffer full / sticky dropped-word flag
//   n_results                     live stored result count
//   rd_start, rd_byte_req         begin serving / request the next byte
//   rd_valid, rd_data, rd_last    served byte (1 cycle after the request)
//   busy                          record is being served
module autotest_result_buffer #(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned HDR_BYTES   = 12,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [31:0]      hdr_signature,
  input  logic [7:0]       hdr_iteration,
  input  logic [31:0]      hdr_n_blocks,
  input  logic [4:0]       hdr_sclk_speed,
  input  logic             hdr_cmd18,
  input  logic             res_valid,
  input  logic [31:0]      res_data,
  output logic             res_ready,
  output logic             full,
  output logic             overflow,
  output logic [CNT_W-1:0] n_results,
  input  logic             rd_start,
  input  logic             rd_byte_req,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             rd_last,
  output logic             busy
);

  localparam int unsigned IDX_W = $clog2(BLOCK_BYTES);
`ifdef AUTOTEST_RESULT_CHECKSUM_EN
  localparam int unsigned CAP = (BLOCK_BYTES - HDR_BYTES) / 4 - 1;
`else
  localparam int unsigned CAP = (BLOCK_BYTES - HDR_BYTES) / 4;
`endif
  localparam int unsigned WIDX_W = (CAP > 1) ? $clog2(CAP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

  typedef enum logic {COLLECT, SERVE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [31:0]      words [CAP];
  logic [IDX_W-1:0] byte_idx;

  logic [31:0]      sig_q;
  logic [7:0]       iter_q;
  logic [31:0]      nblk_q;
  logic [4:0]       sclk_q;
  logic             cmd18_q;

`ifdef AUTOTEST_RESULT_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic [IDX_W-1:0] rec_off;
  logic [IDX_W-1:0] word_pos;
  logic [31:0]      word_sel;
  logic [7:0]       serve_byte;

  assign full      = (count == CNT_W'(CAP));
  assign busy      = (state == SERVE);
  assign res_ready = (state == COLLECT) && !full;
  assign n_results = count;

  // Byte at the current read position, decoded from the header and word buffer
  always_comb begin
    serve_byte = 8'h00;
    rec_off    = byte_idx - IDX_W'(HDR_BYTES);
    word_pos   = rec_off >> 2;
    word_sel   = words[WIDX_W'(word_pos)];
    if (byte_idx < IDX_W'(HDR_BYTES)) begin
      case (byte_idx[3:0])
        4'd0:    serve_byte = sig_q[31:24];
        4'd1:    serve_byte = sig_q[23:16];
        4'd2:    serve_byte = sig_q[15:8];
        4'd3:    serve_byte = sig_q[7:0];
        4'd4:    serve_byte = iter_q;
        4'd5:    serve_byte = nblk_q[31:24];
        4'd6:    serve_byte = nblk_q[23:16];
        4'd7:    serve_byte = nblk_q[15:8];
        4'd8:    serve_byte = nblk_q[7:0];
        4'd9:    serve_byte = {3'b000, sclk_q};
        4'd10:   serve_byte = {7'b0000000, cmd18_q};
        4'd11:   serve_byte = 8'(count);
        default: serve_byte = 8'h00;
      endcase
    end else if (word_pos < IDX_W'(CAP)) begin
      case (rec_off[1:0])
        2'd0:    serve_byte = word_sel[31:24];
        2'd1:    serve_byte = word_sel[23:16];
        2'd2:    serve_byte = word_sel[15:8];
        default: serve_byte = word_sel[7:0];
      endcase
    end
`ifdef AUTOTEST_RESULT_CHECKSUM_EN
    if (byte_idx == LAST_IDX) begin
      serve_byte = csum;
    end
`endif
  end

  // Collect/serve state machine, word storage and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= 8'h00;
      byte_idx <= '0;
      sig_q    <= 32'h0;
      iter_q   <= 8'h00;
      nblk_q   <= 32'h0;
      sclk_q   <= 5'h00;
      cmd18_q  <= 1'b0;
      words    <= '{default: 32'h0};
`ifdef AUTOTEST_RESULT_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      if (clear) begin
        // clear outranks everything: no word store, no byte served
        state    <= COLLECT;
        count    <= '0;
        overflow <= 1'b0;
        byte_idx <= '0;
        words    <= '{default: 32'h0};
        sig_q    <= hdr_signature;
        iter_q   <= hdr_iteration;
        nblk_q   <= hdr_n_blocks;
        sclk_q   <= hdr_sclk_speed;
        cmd18_q  <= hdr_cmd18;
`ifdef AUTOTEST_RESULT_CHECKSUM_EN
        csum     <= 8'h00;
`endif
      end else begin
        if (res_valid && full) begin
          overflow <= 1'b1;
        end
        case (state)
          COLLECT: begin
            // a word offered with rd_start is still stored before serving
            if (res_valid && !full) begin
              words[WIDX_W'(count)] <= res_data;
              count                 <= count + CNT_W'(1);
            end
            if (rd_start) begin
              state    <= SERVE;
              byte_idx <= '0;
`ifdef AUTOTEST_RESULT_CHECKSUM_EN
              csum     <= 8'h00;
`endif
            end
          end
          SERVE: begin
            if (rd_byte_req) begin
              rd_valid <= 1'b1;
              rd_data  <= serve_byte;
              rd_last  <= (byte_idx == LAST_IDX);
`ifdef AUTOTEST_RESULT_CHECKSUM_EN
              if (byte_idx != LAST_IDX) begin
                csum <= csum ^ serve_byte;
              end
`endif
              if (byte_idx == LAST_IDX) begin
                state    <= COLLECT;
                byte_idx <= '0;
              end else begin
                byte_idx <= byte_idx + IDX_W'(1);
              end
            end
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_autotest_result_buffer.sv
// Directed bench for autotest_result_buffer: header map, result packing,
// capacity/overflow, clear priority, request latency and (when built with
// AUTOTEST_RESULT_CHECKSUM_EN) the trailing XOR byte.
module tb_autotest_result_buffer;

  localparam int unsigned BLOCK_BYTES = 512;
  localparam int unsigned HDR_BYTES   = 12;
  localparam int unsigned CNT_W       = 8;
`ifdef AUTOTEST_RESULT_CHECKSUM_EN
  localparam int unsigned CAP = 124;
`else
  localparam int unsigned CAP = 125;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic [31:0]      hdr_signature;
  logic [7:0]       hdr_iteration;
  logic [31:0]      hdr_n_blocks;
  logic [4:0]       hdr_sclk_speed;
  logic             hdr_cmd18;
  logic             res_valid;
  logic [31:0]      res_data;
  logic             res_ready;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] n_results;
  logic             rd_start;
  logic             rd_byte_req;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             rd_last;
  logic             busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] got [BLOCK_BYTES];
  int valid_cnt, last_cnt, last_idx, lat_err, nz_cnt;
  logic [7:0] first_csum;

  autotest_result_buffer #(
    .BLOCK_BYTES(BLOCK_BYTES),
    .HDR_BYTES  (HDR_BYTES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .hdr_signature (hdr_signature),
    .hdr_iteration (hdr_iteration),
    .hdr_n_blocks  (hdr_n_blocks),
    .hdr_sclk_speed(hdr_sclk_speed),
    .hdr_cmd18     (hdr_cmd18),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_ready     (res_ready),
    .full          (full),
    .overflow      (overflow),
    .n_results     (n_results),
    .rd_start      (rd_start),
    .rd_byte_req   (rd_byte_req),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Serves a full record; gap inserts an idle cycle after every request.
  task automatic serve(input bit gap, input bit do_start);
    valid_cnt = 0; last_cnt = 0; last_idx = -1; lat_err = 0;
    if (do_start) begin
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
    end
    for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
      rd_byte_req = 1'b1;
      tick();
      rd_byte_req = 1'b0;
      if (rd_valid) begin
        got[valid_cnt] = rd_data;
        if (rd_last) begin
          last_cnt++;
          last_idx = valid_cnt;
        end
        valid_cnt++;
      end else begin
        lat_err++;
      end
      if (gap) begin
        tick();
        if (rd_valid) lat_err++;
      end
    end
  endtask

  initial begin
    logic [7:0] hdr_exp [12];
    hdr_exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h03, 8'h00, 8'h00, 8'h00,
                8'h10, 8'h05, 8'h01, 8'h00};

    rst = 1'b1; clear = 1'b0; res_valid = 1'b0; res_data = 32'h0;
    rd_start = 1'b0; rd_byte_req = 1'b0;
    hdr_signature = 32'hAABBCCDD; hdr_iteration = 8'd3;
    hdr_n_blocks = 32'h00000010; hdr_sclk_speed = 5'd5; hdr_cmd18 = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_n_results", 32'(n_results), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_ready", 32'(res_ready), 32'd1);

    // Byte request outside SERVE is ignored
    rd_byte_req = 1'b1; tick(); rd_byte_req = 1'b0;
    chk("idle_req_no_valid", 32'(rd_valid), 32'd0);

    // Header-only record, back-to-back requests
    pulse_clear();
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("res_ready_in_serve", 32'(res_ready), 32'd0);
    serve(1'b0, 1'b0);
    chk("hdr_valid_cnt", 32'(valid_cnt), 32'd512);
    chk("hdr_lat_err", 32'(lat_err), 32'd0);
    for (int i = 0; i < 12; i++) chk($sformatf("hdr_byte%0d", i), 32'(got[i]), 32'(hdr_exp[i]));
    nz_cnt = 0;
    for (int i = 12; i < 512; i++) if (got[i] !== 8'h00) nz_cnt++;
`ifdef AUTOTEST_RESULT_CHECKSUM_EN
    nz_cnt = 0;
    for (int i = 12; i < 511; i++) if (got[i] !== 8'h00) nz_cnt++;
`endif
    chk("hdr_tail_nonzero", 32'(nz_cnt), 32'd0);
    chk("hdr_last_cnt", 32'(last_cnt), 32'd1);
    chk("hdr_last_idx", 32'(last_idx), 32'd511);
    chk("busy_after_serve", 32'(busy), 32'd0);

    // Two results, requests separated by idle cycles
    res_valid = 1'b1;
    res_data = 32'h01020304; tick();
    res_data = 32'hA0B0C0D0; tick();
    res_valid = 1'b0;
    chk("two_n_results", 32'(n_results), 32'd2);
    serve(1'b1, 1'b1);
    chk("two_lat_err", 32'(lat_err), 32'd0);
    chk("two_byte11", 32'(got[11]), 32'h02);
    chk("two_word0", {got[12], got[13], got[14], got[15]}, 32'h01020304);
    chk("two_word1", {got[16], got[17], got[18], got[19]}, 32'hA0B0C0D0);
    chk("two_byte20", 32'(got[20]), 32'h00);

    // Fill to capacity, then overflow
    pulse_clear();
    res_valid = 1'b1;
    for (int i = 0; i < int'(CAP); i++) begin
      res_data = 32'(i + 1);
      tick();
    end
    res_valid = 1'b0;
    chk("fill_n_results", 32'(n_results), 32'(CAP));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_res_ready", 32'(res_ready), 32'd0);
    chk("fill_overflow", 32'(overflow), 32'd0);
    serve(1'b0, 1'b1);
    chk("fill_byte11", 32'(got[11]), 32'(CAP));
    chk("fill_lastword_lsb", 32'(got[HDR_BYTES + 4 * (CAP - 1) + 3]), 32'(CAP));
    chk("fill_lastword_msb", 32'(got[HDR_BYTES + 4 * (CAP - 1)]), 32'd0);
    res_valid = 1'b1; res_data = 32'hFFFFFFFF; tick(); res_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_n_results", 32'(n_results), 32'(CAP));
    pulse_clear();
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_n_results", 32'(n_results), 32'd0);
    chk("clr_full", 32'(full), 32'd0);

    // clear in the middle of serving at byte 40
    res_valid = 1'b1; res_data = 32'hDEADBEEF; tick(); res_valid = 1'b0;
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    lat_err = 0;
    for (int i = 0; i < 40; i++) begin
      rd_byte_req = 1'b1; tick();
      if (!rd_valid) lat_err++;
    end
    chk("mid_pre_valid", 32'(lat_err), 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_n_results", 32'(n_results), 32'd0);
    tick();
    chk("mid_req_ignored", 32'(rd_valid), 32'd0);
    rd_byte_req = 1'b0;

    // Simultaneous clear/res_valid and rd_start/res_valid
    clear = 1'b1; res_valid = 1'b1; res_data = 32'h55555555; tick();
    clear = 1'b0; res_valid = 1'b0;
    chk("clr_vs_res", 32'(n_results), 32'd0);
    rd_start = 1'b1; res_valid = 1'b1; res_data = 32'hCAFEF00D; tick();
    rd_start = 1'b0; res_valid = 1'b0;
    chk("start_vs_res_n", 32'(n_results), 32'd1);
    chk("start_vs_res_busy", 32'(busy), 32'd1);
    serve(1'b0, 1'b0);
    chk("start_vs_res_word", {got[12], got[13], got[14], got[15]}, 32'hCAFEF00D);
    chk("start_vs_res_byte11", 32'(got[11]), 32'h01);
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    chk("start_in_serve_busy", 32'(busy), 32'd1);
    serve(1'b0, 1'b0);
    chk("start_in_serve_cnt", 32'(valid_cnt), 32'd512);

`ifdef AUTOTEST_RESULT_CHECKSUM_EN
    // Trailing XOR byte over the header plus one result
    pulse_clear();
    res_valid = 1'b1; res_data = 32'h11223344; tick(); res_valid = 1'b0;
    serve(1'b0, 1'b1);
    chk("csum_byte511", 32'(got[511]), 32'h52);
    chk("csum_last_idx", 32'(last_idx), 32'd511);
    first_csum = got[511];
    serve(1'b1, 1'b1);
    chk("csum_reserve", 32'(got[511]), 32'(first_csum));
    chk("csum_reserve_word", {got[12], got[13], got[14], got[15]}, 32'h11223344);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
